wrr_arbiter: RTL and testbench
==============================

WRR_ARBITER -- requirements
Module: wrr_arbiter

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the number of requesters (2..16).
REQ-002 Parameter CW, default 4, SHALL set the per-requester weight/credit width in bits.
REQ-003 clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 req  input  WIDTH  SHALL carry per-requester request levels; bit i is held high while requester i wants the resource.
REQ-006 weight  input  WIDTH*CW  SHALL carry packed static weights: slice [i*CW +: CW] is requester i's weight, i.e. beats per tenure.
REQ-007 grant  output  WIDTH  SHALL be a registered, one-hot-or-zero grant vector.
REQ-008 owner  output  $clog2(WIDTH)  SHALL give the index of the current grantee, valid when busy=1.
REQ-009 busy  output  1  SHALL be high whenever grant is nonzero.

Function
REQ-010 The block SHALL have two states: IDLE (grant=0) and OWN (exactly one grant bit set).
REQ-011 Arbitration SHALL select the first set req bit at or above the one-hot base pointer, scanning upward with wrap-around from bit WIDTH-1 to bit 0.
REQ-012 In IDLE with any req set, the next edge SHALL enter OWN, set grant for the winner and load credit with the winner's weight; grant latency from req rise SHALL be 1 cycle.
REQ-013 A weight of 0 SHALL be treated as 1.
REQ-014 Each OWN cycle with req[owner]=1 SHALL count as one beat and decrement credit by 1.
REQ-015 Tenure SHALL end at the edge after the beat that brings credit to 0, or at the edge after a cycle in OWN with req[owner]=0.
REQ-016 At tenure end, base SHALL become owner+1, wrapping from WIDTH-1 to 0.
REQ-017 At tenure end, arbitration SHALL be evaluated in the same edge using the new base:
- If any req is set, grant SHALL hand over directly with no idle cycle.
- The old owner SHALL be eligible only if no other req is set.
- If no req is set, the block SHALL return to IDLE.
REQ-018 A requester lowering req before receiving grant SHALL have no effect beyond losing eligibility.
REQ-019 Weight changes SHALL take effect only at the next credit load.
REQ-020 With a single persistent requester, grant SHALL remain continuously asserted across tenure boundaries, with credit reloading.
REQ-021 owner SHALL equal the binary encoding of grant; busy SHALL equal |grant.

Reset
REQ-022 While reset=1, the following SHALL hold at the next edge: grant=0, busy=0, owner=0, base=1 (requester 0), credit=0, state=IDLE.
REQ-023 Reset asserted mid-tenure SHALL drop grant at the next edge regardless of credit or lock.
REQ-024 On the first edge after reset deasserts, normal arbitration from base=1 SHALL apply.

Configuration
REQ-025 Macro WRR_LOCK_EN SHALL, when defined, add input lock (1 bit).
REQ-026 With WRR_LOCK_EN defined and lock=1 during OWN, credit SHALL neither decrement nor end tenure; only req[owner]=0 or reset SHALL end tenure.
REQ-027 With WRR_LOCK_EN defined and lock=1, credit SHALL be held at its current value; after lock falls, decrementing SHALL resume from that value.
REQ-028 With WRR_LOCK_EN undefined, the lock port SHALL be absent and behaviour SHALL be exactly REQ-010..REQ-021.

Verification
REQ-029 Bench SHALL cover: WIDTH=4, all weights 1, req=4'b1111 constant -> grant sequence 0001, 0010, 0100, 1000, 0001, each held 1 cycle.
REQ-030 Bench SHALL cover: weights {1,1,1,3} (req3 weight 3), req=4'b1001 -> grant 0001 for 1 cycle, then 1000 for 3 cycles, then 0001.
REQ-031 Bench SHALL cover: req0 alone with weight 2, dropped after 1 beat -> grant 0001 ends 1 cycle after the req fall, then busy=0.
REQ-032 Bench SHALL cover: weight 0 on req2 alone -> grant 0100 continuously asserted, credit reloading every cycle.
REQ-033 Bench SHALL cover: reset pulsed while grant=0100 with credit 3 -> grant=0 next edge; after release with req=4'b0110, first grant is 0010.
REQ-034 Bench SHALL cover, with WRR_LOCK_EN: lock=1 during a weight-1 tenure with req=4'b0011 -> grant 0001 held until lock=0, then one beat, then hand-over to 0010.

Source files
------------

// File: rtl/wrr_arbiter_if.sv
// Request/grant bundle between requesters (master) and the weighted round-robin arbiter (slave).
interface wrr_arbiter_if #(
    parameter int WIDTH = 4,
    parameter int CW    = 4
);
    logic [WIDTH-1:0]         req;
    logic [WIDTH*CW-1:0]      weight;
    logic [WIDTH-1:0]         grant;
    logic [$clog2(WIDTH)-1:0] owner;
    logic                     busy;

    modport master (
        output req,
        output weight,
        input  grant,
        input  owner,
        input  busy
    );

    modport slave (
        input  req,
        input  weight,
        output grant,
        output owner,
        output busy
    );
endinterface

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: one-hot base pointer, per-tenure credit loaded from weight.
// Optional macro WRR_LOCK_EN adds a lock input that freezes credit during a tenure.
module wrr_arbiter #(
    parameter int WIDTH = 4,
    parameter int CW    = 4
) (
    input  logic clk,
    input  logic reset,
`ifdef WRR_LOCK_EN
    input  logic lock,
`endif
    wrr_arbiter_if.slave bus
);
    localparam int IW = $clog2(WIDTH);

    typedef enum logic {IDLE, OWN} state_t;

    state_t           state;
    logic [WIDTH-1:0] base;
    logic [CW-1:0]    credit;

    logic [WIDTH-1:0] arb_base;
    logic             win_found;
    logic [IW-1:0]    win_idx;
    logic [CW-1:0]    win_weight;
    logic [CW-1:0]    load_credit;
    logic             hold;
    logic             tenure_end;

`ifdef WRR_LOCK_EN
    assign hold = lock;
`else
    assign hold = 1'b0;
`endif

    // At tenure end the scan starts just above the owner, which leaves the old
    // owner last in scan order: it wins only when nobody else is asking.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        int base_idx;
        int j;
        arb_base  = (state == OWN) ? {bus.grant[WIDTH-2:0], bus.grant[WIDTH-1]} : base;
        base_idx  = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (arb_base[i]) base_idx = i;
        end
        for (int i = 0; i < WIDTH; i++) begin
            j = base_idx + i;
            if (j >= WIDTH) j = j - WIDTH;
            if (!win_found && bus.req[j]) begin
                win_found = 1'b1;
                win_idx   = IW'(j);
            end
        end
    end

    assign win_weight  = bus.weight[win_idx*CW +: CW];
    assign load_credit = (win_weight == '0) ? CW'(1) : win_weight;
    assign tenure_end  = !bus.req[bus.owner] || (!hold && credit == CW'(1));
    assign bus.busy    = |bus.grant;

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            base      <= WIDTH'(1);
            credit    <= '0;
            bus.grant <= '0;
            bus.owner <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state     <= OWN;
                        bus.grant <= WIDTH'(1) << win_idx;
                        bus.owner <= win_idx;
                        credit    <= load_credit;
                    end
                end
                OWN: begin
                    if (tenure_end) begin
                        base <= arb_base;
                        if (win_found) begin
                            bus.grant <= WIDTH'(1) << win_idx;
                            bus.owner <= win_idx;
                            credit    <= load_credit;
                        end else begin
                            state     <= IDLE;
                            bus.grant <= '0;
                            bus.owner <= '0;
                            credit    <= '0;
                        end
                    end else if (!hold) begin
                        credit <= credit - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wrr_arbiter.sv
// Self-checking bench for wrr_arbiter: directed literal sequences plus randomized
// traffic compared every cycle against an integer-level model of the arbitration rules.
module tb_wrr_arbiter;
    localparam int WIDTH = 4;
    localparam int CW    = 4;

    logic clk = 1'b0;
    logic reset;
    logic lock;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   chk_en   = 1'b0;

    wrr_arbiter_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

    wrr_arbiter #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
`ifdef WRR_LOCK_EN
        .lock  (lock),
`endif
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

`ifdef WRR_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    // Model state: owner index or -1 when idle, remaining beats, base index.
    int m_owner  = -1;
    int m_credit = 0;
    int m_base   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int pick(input int start);
        for (int k = 0; k < WIDTH; k++) begin
            int idx;
            idx = (start + k) % WIDTH;
            if (bus.req[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int eff_weight(input int idx);
        int w;
        w = int'(bus.weight[idx*CW +: CW]);
        return (w == 0) ? 1 : w;
    endfunction

    always @(posedge clk) begin
        int  w;
        bit  done;
        if (reset) begin
            m_owner  = -1;
            m_credit = 0;
            m_base   = 0;
        end else if (m_owner < 0) begin
            w = pick(m_base);
            if (w >= 0) begin
                m_owner  = w;
                m_credit = eff_weight(w);
            end
        end else begin
            done = 1'b0;
            if (!bus.req[m_owner]) done = 1'b1;
            else if (!(LOCK_EN && lock)) begin
                m_credit = m_credit - 1;
                if (m_credit == 0) done = 1'b1;
            end
            if (done) begin
                m_base = (m_owner + 1) % WIDTH;
                w = pick(m_base);
                if (w >= 0) begin
                    m_owner  = w;
                    m_credit = eff_weight(w);
                end else begin
                    m_owner  = -1;
                    m_credit = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_grant", 32'(bus.grant), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
            check("model_owner", 32'(bus.owner), (m_owner < 0) ? 32'd0 : 32'(m_owner));
            check("model_busy",  32'(bus.busy),  (m_owner < 0) ? 32'd0 : 32'd1);
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        bus.req = '0;
        lock    = 1'b0;
        cyc();
        reset   = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        lock       = 1'b0;
        bus.req    = '0;
        bus.weight = '0;
        cyc();
        cyc();
        check("reset_grant", 32'(bus.grant), 32'd0);
        check("reset_busy",  32'(bus.busy),  32'd0);
        check("reset_owner", 32'(bus.owner), 32'd0);
        chk_en = 1'b1;

        // All weights 1, everyone requesting: one cycle each in index order.
        reset      = 1'b0;
        bus.weight = {4'd1, 4'd1, 4'd1, 4'd1};
        bus.req    = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            cyc();
            check("rr_seq", 32'(bus.grant), 32'd1 << (k % 4));
        end

        // Requester 3 weight 3 against requester 0 weight 1.
        do_reset();
        bus.weight = {4'd3, 4'd1, 4'd1, 4'd1};
        bus.req    = 4'b1001;
        cyc(); check("w3_a", 32'(bus.grant), 32'h1);
        cyc(); check("w3_b", 32'(bus.grant), 32'h8);
        cyc(); check("w3_c", 32'(bus.grant), 32'h8);
        cyc(); check("w3_d", 32'(bus.grant), 32'h8);
        cyc(); check("w3_e", 32'(bus.grant), 32'h1);

        // Requester 0 weight 2 drops after one beat.
        do_reset();
        bus.weight = {4'd1, 4'd1, 4'd1, 4'd2};
        bus.req    = 4'b0001;
        cyc(); check("drop_grant", 32'(bus.grant), 32'h1);
        cyc(); check("drop_beat",  32'(bus.grant), 32'h1);
        bus.req = 4'b0000;
        cyc(); check("drop_end",   32'(bus.grant), 32'h0);
        check("drop_busy", 32'(bus.busy), 32'd0);

        // Weight 0 acts as 1; a lone requester keeps grant continuously.
        do_reset();
        bus.weight = '0;
        bus.req    = 4'b0100;
        for (int k = 0; k < 8; k++) begin
            cyc();
            check("w0_hold", 32'(bus.grant), 32'h4);
        end

        // Reset mid-tenure, then restart from base 0.
        do_reset();
        bus.weight = {4'd1, 4'd3, 4'd1, 4'd1};
        bus.req    = 4'b0100;
        cyc(); check("mid_grant", 32'(bus.grant), 32'h4);
        reset = 1'b1;
        cyc(); check("mid_reset", 32'(bus.grant), 32'h0);
        reset   = 1'b0;
        bus.req = 4'b0110;
        cyc(); check("mid_restart", 32'(bus.grant), 32'h2);

`ifdef WRR_LOCK_EN
        // Lock holds a weight-1 tenure until it falls.
        do_reset();
        bus.weight = {4'd1, 4'd1, 4'd1, 4'd1};
        bus.req    = 4'b0011;
        lock       = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("lock_hold", 32'(bus.grant), 32'h1);
        end
        lock = 1'b0;
        cyc(); check("lock_release", 32'(bus.grant), 32'h2);
`endif

        // Randomized traffic: sticky requests, occasional weight/lock changes and resets.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0) bus.req = WIDTH'($urandom);
            if ($urandom_range(0, 15) == 0) bus.weight = (WIDTH*CW)'($urandom);
            if ($urandom_range(0, 7) == 0) lock = 1'($urandom);
            reset = ($urandom_range(0, 199) == 0);
            cyc();
        end
        reset   = 1'b0;
        bus.req = '0;
        lock    = 1'b0;
        cyc();
        cyc();
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
